pic_inta_sequencer: RTL and testbench

- Downstream stage of the 8259-style priority resolver: takes the winning request level and runs the two-pulse INTA handshake (8086 mode).
- Raises INT to the CPU, freezes the level on the first INTA, sets the ISR bit, clears the IRR bit, and drives the vector on the second INTA.
- Owns the ISR register and services EOI commands: non-specific, specific, and automatic EOI. Fixed priority: IR0 is highest.

---
 rtl/pic_pkg.sv | 27 ++
 rtl/pic_inta_sequencer_if.sv | 33 +++
 rtl/pic_isr_reg.sv | 36 +++
 rtl/pic_inta_sequencer.sv | 148 ++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style interrupt controller blocks.
// Holds sequencer state codes, IR sizing and the fully-nested priority helper.
package pic_pkg;

    localparam int unsigned LEVEL_W = 3;
    localparam int unsigned NUM_IR  = 8;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StPend = 2'd1;
    localparam state_t StAck1 = 2'd2;
    localparam state_t StAck2 = 2'd3;

    // Index of the lowest set bit (highest priority); NUM_IR when nothing is set.
    function automatic logic [LEVEL_W:0] lowest_set(input logic [NUM_IR-1:0] v);
        logic [LEVEL_W:0] idx;
        idx = (LEVEL_W + 1)'(NUM_IR);
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = (LEVEL_W + 1)'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// Request, INTA/vector bus and EOI command signals of the INTA sequencer.
// slave is the sequencer's view; master is the view of whoever drives it.
interface pic_inta_sequencer_if;
    import pic_pkg::*;

    logic               req_valid;
    logic [LEVEL_W-1:0] req_level;
    logic               inta_n;
    logic [4:0]         vec_base;
    logic               aeoi;
    logic               eoi_valid;
    logic               eoi_specific;
    logic [LEVEL_W-1:0] eoi_level;
    logic               int_out;
    logic [NUM_IR-1:0]  isr;
    logic [NUM_IR-1:0]  irr_clr;
    logic [7:0]         data_out;
    logic               data_oe;
    logic               seq_timeout;

    modport slave (
        input  req_valid, req_level, inta_n, vec_base, aeoi,
        input  eoi_valid, eoi_specific, eoi_level,
        output int_out, isr, irr_clr, data_out, data_oe, seq_timeout
    );

    modport master (
        output req_valid, req_level, inta_n, vec_base, aeoi,
        output eoi_valid, eoi_specific, eoi_level,
        input  int_out, isr, irr_clr, data_out, data_oe, seq_timeout
    );

endinterface

// File: rtl/pic_isr_reg.sv
// In-service register: one set port and a clear mask per cycle.
// A set and a clear of the same bit in one cycle leaves the bit set.
module pic_isr_reg
    import pic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en_i,
    input  logic [LEVEL_W-1:0] set_level_i,
    input  logic [NUM_IR-1:0]  clr_mask_i,
    output logic [NUM_IR-1:0]  isr_o
);

    logic [NUM_IR-1:0] isr_q;
    logic [NUM_IR-1:0] isr_d;
    logic [NUM_IR-1:0] set_mask;

    always_comb begin
        set_mask = '0;
        if (set_en_i) begin
            set_mask[set_level_i] = 1'b1;
        end
        isr_d = (isr_q & ~clr_mask_i) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            isr_q <= '0;
        end else begin
            isr_q <= isr_d;
        end
    end

    assign isr_o = isr_q;

endmodule

// File: rtl/pic_inta_sequencer.sv
// Two-pulse (8086-mode) INTA handshake for the winning request level.
// Raises INT, commits the ISR bit on INTA1, drives the vector on INTA2, services EOIs.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned SPURIOUS_LEVEL = 7
) (
    input logic                 clk,
    input logic                 rst,
    pic_inta_sequencer_if.slave bus
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_q, state_d;
    logic               inta_prev_q;
    logic [1:0]         inta_cnt_q, inta_cnt_d;
    logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [LEVEL_W-1:0] lvl_q, lvl_d;
    logic               spur_q, spur_d;
    logic [NUM_IR-1:0]  irr_clr_q, irr_clr_d;
    logic               seq_timeout_q, seq_timeout_d;

    logic [NUM_IR-1:0]  isr;
    logic [LEVEL_W:0]   isr_top;
    logic               qualify;
    logic               inta_fall;
    logic               isr_set;
    logic [NUM_IR-1:0]  aeoi_clr;
    logic [NUM_IR-1:0]  eoi_clr;
    logic               data_oe;

    assign isr_top   = lowest_set(isr);
    assign qualify   = bus.req_valid && ({1'b0, bus.req_level} < isr_top);
    assign inta_fall = inta_prev_q && !bus.inta_n;

    always_comb begin
        state_d       = state_q;
        inta_cnt_d    = inta_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        lvl_d         = lvl_q;
        spur_d        = spur_q;
        irr_clr_d     = '0;
        seq_timeout_d = 1'b0;
        isr_set       = 1'b0;
        aeoi_clr      = '0;
        case (state_q)
            StIdle: begin
                inta_cnt_d = 2'd0;
                if (qualify) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                // INTA wins over a request that vanishes in the same cycle: spurious vector.
                if (inta_fall) begin
                    state_d    = StAck1;
                    inta_cnt_d = 2'd1;
                    tmo_cnt_d  = TmoW'(TIMEOUT_CYCLES);
                    if (bus.req_valid) begin
                        lvl_d                     = bus.req_level;
                        spur_d                    = 1'b0;
                        isr_set                   = 1'b1;
                        irr_clr_d[bus.req_level]  = 1'b1;
                    end else begin
                        lvl_d  = LEVEL_W'(SPURIOUS_LEVEL);
                        spur_d = 1'b1;
                    end
                end else if (!qualify) begin
                    state_d = StIdle;
                end
            end
            StAck1: begin
                if (inta_fall) begin
                    state_d    = StAck2;
                    inta_cnt_d = 2'd2;
                end else if (tmo_cnt_q <= TmoW'(1)) begin
                    state_d       = StIdle;
                    seq_timeout_d = 1'b1;
                    tmo_cnt_d     = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TmoW'(1);
                end
            end
            StAck2: begin
                if (bus.inta_n) begin
                    state_d = StIdle;
                    if (bus.aeoi && !spur_q) begin
                        aeoi_clr[lvl_q] = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        eoi_clr = '0;
        if (bus.eoi_valid) begin
            if (bus.eoi_specific) begin
                eoi_clr[bus.eoi_level] = 1'b1;
            end else if (!isr_top[LEVEL_W]) begin
                eoi_clr[isr_top[LEVEL_W-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            inta_prev_q   <= 1'b1;
            inta_cnt_q    <= 2'd0;
            tmo_cnt_q     <= '0;
            lvl_q         <= '0;
            spur_q        <= 1'b0;
            irr_clr_q     <= '0;
            seq_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            inta_prev_q   <= bus.inta_n;
            inta_cnt_q    <= inta_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            lvl_q         <= lvl_d;
            spur_q        <= spur_d;
            irr_clr_q     <= irr_clr_d;
            seq_timeout_q <= seq_timeout_d;
        end
    end

    pic_isr_reg u_isr_reg (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (isr_set),
        .set_level_i (lvl_d),
        .clr_mask_i  (eoi_clr | aeoi_clr),
        .isr_o       (isr)
    );

    assign data_oe         = (state_q == StAck2) && !bus.inta_n;
    assign bus.data_oe     = data_oe;
    assign bus.data_out    = data_oe ? {bus.vec_base, lvl_q} : 8'h00;
    assign bus.int_out     = (state_q == StPend);
    assign bus.isr         = isr;
    assign bus.irr_clr     = irr_clr_q;
    assign bus.seq_timeout = seq_timeout_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: directed scenarios plus random
// request/EOI traffic checked against a transaction-level ISR model.
module tb_pic_inta_sequencer;

    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pic_inta_sequencer_if bus ();

    pic_inta_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .SPURIOUS_LEVEL (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] model_isr;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Highest-priority in-service level under fixed priority, 8 when idle.
    function automatic int model_top(input logic [7:0] v);
        int top;
        top = 8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) top = i;
        end
        return top;
    endfunction

    task automatic raise(input logic [2:0] lvl, input logic exp_int);
        bus.req_valid = 1'b1;
        bus.req_level = lvl;
        @(negedge clk);
        check("int_out_after_req", {15'd0, bus.int_out}, {15'd0, exp_int});
    endtask

    task automatic ack_seq(input logic [2:0] lvl, input logic spur, input logic coll);
        logic [7:0] bit_m;
        logic [2:0] vlvl;
        bit_m = spur ? 8'h00 : (8'h01 << lvl);
        vlvl  = spur ? 3'd7 : lvl;
        bus.inta_n = 1'b0;
        if (spur) bus.req_valid = 1'b0;
        if (coll) begin
            bus.eoi_valid    = 1'b1;
            bus.eoi_specific = 1'b1;
            bus.eoi_level    = lvl;
        end
        @(negedge clk);
        bus.eoi_valid = 1'b0;
        bus.req_valid = 1'b0;
        model_isr = model_isr | bit_m;
        check("irr_clr_ack1", {8'd0, bus.irr_clr}, {8'd0, bit_m});
        check("isr_ack1", {8'd0, bus.isr}, {8'd0, model_isr});
        check("int_out_ack1", {15'd0, bus.int_out}, 16'd0);
        check("data_oe_ack1", {15'd0, bus.data_oe}, 16'd0);
        @(negedge clk);
        check("irr_clr_one_cycle", {8'd0, bus.irr_clr}, 16'd0);
        bus.inta_n = 1'b1;
        @(negedge clk);
        bus.inta_n = 1'b0;
        @(negedge clk);
        check("data_oe_ack2", {15'd0, bus.data_oe}, 16'd1);
        check("vector", {8'd0, bus.data_out}, {8'd0, bus.vec_base, vlvl});
        bus.inta_n = 1'b1;
        #1;
        check("data_oe_release", {15'd0, bus.data_oe}, 16'd0);
        check("data_out_release", {8'd0, bus.data_out}, 16'd0);
        @(negedge clk);
        if (bus.aeoi && !spur) model_isr = model_isr & ~bit_m;
        check("isr_after_seq", {8'd0, bus.isr}, {8'd0, model_isr});
    endtask

    task automatic eoi(input logic specific, input logic [2:0] lvl);
        int top;
        bus.eoi_valid    = 1'b1;
        bus.eoi_specific = specific;
        bus.eoi_level    = lvl;
        @(negedge clk);
        bus.eoi_valid = 1'b0;
        top = model_top(model_isr);
        if (specific) model_isr[lvl] = 1'b0;
        else if (top < 8) model_isr[top] = 1'b0;
        check("isr_after_eoi", {8'd0, bus.isr}, {8'd0, model_isr});
    endtask

    initial begin
        logic       seen;
        logic       oe_seen;
        int         n;
        logic [2:0] lvl;
        logic       q;

        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_level    = 3'd0;
        bus.inta_n       = 1'b1;
        bus.vec_base     = 5'd0;
        bus.aeoi         = 1'b0;
        bus.eoi_valid    = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.eoi_level    = 3'd0;
        model_isr        = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_int_out", {15'd0, bus.int_out}, 16'd0);
        check("rst_isr", {8'd0, bus.isr}, 16'd0);
        check("rst_irr_clr", {8'd0, bus.irr_clr}, 16'd0);
        check("rst_data_oe", {15'd0, bus.data_oe}, 16'd0);
        check("rst_data_out", {8'd0, bus.data_out}, 16'd0);
        check("rst_timeout", {15'd0, bus.seq_timeout}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sequence, level 3, vector 0x43.
        bus.vec_base = 5'b01000;
        raise(3'd3, 1'b1);
        ack_seq(3'd3, 1'b0, 1'b0);
        check("basic_isr", {8'd0, bus.isr}, 16'h0008);
        eoi(1'b0, 3'd0);

        // Automatic EOI.
        bus.aeoi = 1'b1;
        raise(3'd3, 1'b1);
        ack_seq(3'd3, 1'b0, 1'b0);
        check("aeoi_isr", {8'd0, bus.isr}, 16'h0000);
        bus.aeoi = 1'b0;

        // Fully nested: IR2 in service blocks IR5, admits IR1.
        raise(3'd2, 1'b1);
        ack_seq(3'd2, 1'b0, 1'b0);
        raise(3'd5, 1'b0);
        @(negedge clk);
        check("blocked_int_out", {15'd0, bus.int_out}, 16'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        raise(3'd1, 1'b1);
        ack_seq(3'd1, 1'b0, 1'b0);
        check("nested_isr", {8'd0, bus.isr}, 16'h0006);
        eoi(1'b0, 3'd0);
        check("nonspec_eoi_isr", {8'd0, bus.isr}, 16'h0004);

        // Request vanishes as INTA1 arrives: spurious vector, no ISR/IRR change.
        raise(3'd0, 1'b1);
        ack_seq(3'd0, 1'b1, 1'b0);
        check("spurious_isr", {8'd0, bus.isr}, 16'h0004);

        // INTA pulse while idle must not drive the bus.
        bus.inta_n = 1'b0;
        @(negedge clk);
        check("idle_inta_oe", {15'd0, bus.data_oe}, 16'd0);
        bus.inta_n = 1'b1;
        @(negedge clk);
        check("idle_inta_isr", {8'd0, bus.isr}, 16'h0004);

        // Specific EOI colliding with the ACK1 set of the same bit.
        eoi(1'b1, 3'd2);
        raise(3'd3, 1'b1);
        ack_seq(3'd3, 1'b0, 1'b1);
        check("collision_isr3", {15'd0, bus.isr[3]}, 16'd1);

        // Missing INTA2: timeout.
        raise(3'd1, 1'b1);
        bus.inta_n = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.inta_n    = 1'b1;
        model_isr     = model_isr | 8'h02;
        check("tmo_isr_ack1", {8'd0, bus.isr}, {8'd0, model_isr});
        seen    = 1'b0;
        oe_seen = 1'b0;
        n       = 0;
        while (n < int'(TMO) + 8 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.data_oe) oe_seen = 1'b1;
            if (bus.seq_timeout) seen = 1'b1;
        end
        check("timeout_seen", {15'd0, seen}, 16'd1);
        check("timeout_window", {15'd0, (n >= int'(TMO) && n <= int'(TMO) + 1)}, 16'd1);
        check("timeout_no_oe", {15'd0, oe_seen}, 16'd0);
        check("timeout_isr_kept", {8'd0, bus.isr}, {8'd0, model_isr});
        @(negedge clk);
        check("timeout_one_cycle", {15'd0, bus.seq_timeout}, 16'd0);

        // Back in IDLE: a new request is taken; then reset during ACK1.
        raise(3'd0, 1'b1);
        bus.inta_n = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_pre_isr", {8'd0, bus.isr}, {8'd0, model_isr | 8'h01});
        rst        = 1'b1;
        bus.inta_n = 1'b1;
        @(negedge clk);
        check("ack1_rst_isr", {8'd0, bus.isr}, 16'd0);
        check("ack1_rst_irr", {8'd0, bus.irr_clr}, 16'd0);
        check("ack1_rst_int", {15'd0, bus.int_out}, 16'd0);
        check("ack1_rst_oe", {15'd0, bus.data_oe}, 16'd0);
        check("ack1_rst_data", {8'd0, bus.data_out}, 16'd0);
        check("ack1_rst_tmo", {15'd0, bus.seq_timeout}, 16'd0);
        rst       = 1'b0;
        model_isr = 8'h00;
        @(negedge clk);

        // Random request / EOI traffic against the ISR model.
        for (int it = 0; it < 60; it++) begin
            lvl          = 3'($urandom_range(0, 7));
            bus.vec_base = 5'($urandom);
            bus.aeoi     = 1'($urandom_range(0, 1));
            q            = (int'(lvl) < model_top(model_isr));
            raise(lvl, q);
            if (q) begin
                ack_seq(lvl, 1'b0, 1'b0);
            end else begin
                bus.req_valid = 1'b0;
                @(negedge clk);
                check("rand_blocked", {15'd0, bus.int_out}, 16'd0);
            end
            if ($urandom_range(0, 1) == 1) begin
                eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
